// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// elaboration-time helpers for the digit count and digit-counter width.
package digit_serial_adder_pkg;

  // FSM state type with legacy-compatible constant encodings.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  // Number of digits in one operand.
  function automatic int calc_ndig(input int width, input int digit);
    if (digit > 0) begin
      return width / digit;
    end else begin
      return 1;
    end
  endfunction

  // Digit counter width; a single-digit operand still gets a 1-bit counter.
  function automatic int cnt_width(input int ndig);
    if (ndig <= 1) begin
      return 1;
    end else begin
      return $clog2(ndig);
    end
  endfunction

endpackage

// File: rtl/digit_serial_adder_cell.sv
// digit_add_cell: combinational DIGIT-bit ripple adder built from per-bit
// full-adder equations. Also exposes the carry into its top bit so the
// caller can form signed overflow on the most significant digit.
module digit_add_cell #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             co_o,
  output logic             ctop_o
);

  logic [DIGIT:0]   c_s;
  logic [DIGIT-1:0] s_s;

  // Ripple the carry through DIGIT full adders.
  always_comb begin
    c_s    = '0;
    s_s    = '0;
    c_s[0] = c_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_s[i]   = a_i[i] ^ b_i[i] ^ c_s[i];
      c_s[i+1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign s_o    = s_s;
  assign co_o   = c_s[DIGIT];
  assign ctop_o = c_s[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits
// per clock, with valid/ready handshakes on both sides. Reports sum,
// unsigned carry-out and signed overflow.
// Optional macro DIGIT_SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into a - b (carry = 1 means no borrow).
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int            NDIG     = calc_ndig(WIDTH, DIGIT);
  localparam int            CW       = cnt_width(NDIG);
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cr_q, cr_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT-1:0]  dsum_s;
  logic              dco_s;
  logic              dctop_s;
  logic              sub_s;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  digit_add_cell #(
    .DIGIT (DIGIT)
  ) u_cell (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .c_i    (cr_q),
    .s_o    (dsum_s),
    .co_o   (dco_s),
    .ctop_o (dctop_s)
  );

  // Next-state logic: accept operands, step one digit per cycle, hold result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cr_d    = cr_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the carry register seeds the +1.
          a_d     = a;
          b_d     = sub_s ? ~b : b;
          cr_d    = sub_s ? 1'b1 : ci;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // New digit enters at the MSB end; after NDIG steps it is aligned.
        sh_d  = WIDTH'({dsum_s, sh_q} >> DIGIT);
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cr_d  = dco_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sh_d;
          carry_d = dco_s;
          ovf_d   = dctop_s ^ dco_s;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cr_q    <= cr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule
